// File: rtl/dwc_row_feeder_pkg.sv
// Shared types and constants for the depthwise-conv row feeder (package dwc_pkg).
// The optional horizontal padding build is selected with DWC_FEEDER_PAD_EN.
package dwc_pkg;
    localparam int DATA_W      = 8;
    localparam int MAX_W       = 64;
    localparam int H_W         = 10;
    localparam int ROWS        = 6;
    localparam int STRIDE_ROWS = 4;
    localparam int AW          = $clog2(MAX_W);
    localparam int CW          = AW + 1;

    typedef logic signed [DATA_W-1:0] pix_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    // (a + b) mod 6 for rotation/bank arithmetic; operands are always < 6.
    function automatic logic [2:0] rot_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd6) s = s - 4'd6;
        return s[2:0];
    endfunction
endpackage

// File: rtl/dwc_row_feeder_if.sv
// Pixel input stream and column output bundle of the row feeder.
// slave = the feeder itself, master = upstream source / downstream dwc unit.
interface dwc_row_feeder_if;
    import dwc_pkg::*;

    logic s_valid;
    pix_t s_data;
    logic s_ready;

    logic out_valid;
    logic strip_start;
    pix_t out_row0;
    pix_t out_row1;
    pix_t out_row2;
    pix_t out_row3;
    pix_t out_row4;
    pix_t out_row5;

    modport slave (
        input  s_valid, s_data,
        output s_ready,
        output out_valid, strip_start,
        output out_row0, out_row1, out_row2, out_row3, out_row4, out_row5
    );

    modport master (
        output s_valid, s_data,
        input  s_ready,
        input  out_valid, strip_start,
        input  out_row0, out_row1, out_row2, out_row3, out_row4, out_row5
    );
endinterface

// File: rtl/dwc_row_bank.sv
// One line-buffer row: MAX_W x DATA_W single-port RAM with a registered read.
// Writes and reads are never issued in the same cycle by the controller.
module dwc_row_bank
    import dwc_pkg::*;
(
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  pix_t          wdata_i,
    output pix_t          rdata_o
);
    pix_t mem_q [MAX_W];
    pix_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dwc_row_feeder.sv
// Rotating six-row line buffer that replays 6-row strips column by column.
// Build option: DWC_FEEDER_PAD_EN adds one zero column on each side of every strip.
//
// state  | meaning
// IDLE   | waiting for a valid start
// FILL   | accepting pixels into the rows this strip still needs
// STREAM | reading one column per cycle from all six banks
// NEXT   | advance base row / rotation, or finish
// DONE   | one-cycle frame_done pulse
module dwc_row_feeder
    import dwc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    cfg_width,
    input  logic [H_W-1:0]   cfg_height,
    output logic             cfg_err,
    output logic             busy,
    output logic             frame_done,
    dwc_row_feeder_if.slave  io
);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_FILL   = ST_FILL;
    localparam logic [2:0] S_STREAM = ST_STREAM;
    localparam logic [2:0] S_NEXT   = ST_NEXT;
    localparam logic [2:0] S_DONE   = ST_DONE;

`ifdef DWC_FEEDER_PAD_EN
    localparam bit            PAD_EN   = 1'b1;
    localparam logic [CW-1:0] PAD_COLS = CW'(2);
    localparam logic [CW-1:0] LEAD     = CW'(1);
`else
    localparam bit            PAD_EN   = 1'b0;
    localparam logic [CW-1:0] PAD_COLS = CW'(0);
    localparam logic [CW-1:0] LEAD     = CW'(0);
`endif

    logic [2:0]      state_q, state_d;
    logic [2:0]      rot_q, rot_d;
    logic [H_W-1:0]  base_q, base_d;
    logic [2:0]      fill_row_q, fill_row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [5:0]      zmask_q, zmask_d;
    logic [CW-1:0]   width_q, width_d;
    logic [H_W-1:0]  height_q, height_d;
    logic            cfg_err_q, cfg_err_d;
    logic            out_valid_q, pad_q, strip_start_q;

    logic            cfg_ok, s_ready, xfer, row_last_col, last_row, strip_end, pad_col, rd_en;
    logic [H_W-1:0]  abs_row;
    logic [CW-1:0]   ncol, rd_col;
    logic [2:0]      wr_bank;
    logic [AW-1:0]   addr;
    pix_t            rdata  [ROWS];
    pix_t            out_row[ROWS];

    assign cfg_ok       = (cfg_width != '0) && (cfg_width <= CW'(MAX_W)) && (cfg_height >= H_W'(3));
    assign abs_row      = base_q + H_W'(fill_row_q);
    assign s_ready      = (state_q == S_FILL) && (abs_row < height_q);
    assign xfer         = io.s_valid && s_ready;
    assign row_last_col = (col_q == width_q - CW'(1));
    assign last_row     = (fill_row_q == 3'd5) ||
                          (({1'b0, abs_row} + (H_W+1)'(1)) >= {1'b0, height_q});
    assign strip_end    = ({1'b0, base_q} + (H_W+1)'(ROWS)) >= {1'b0, height_q};
    assign ncol         = width_q + PAD_COLS;
    assign pad_col      = PAD_EN && ((col_q == '0) || (col_q == ncol - CW'(1)));
    assign rd_en        = (state_q == S_STREAM);
    assign rd_col       = col_q - LEAD;
    assign addr         = (state_q == S_FILL) ? col_q[AW-1:0] : rd_col[AW-1:0];
    assign wr_bank      = rot_add(rot_q, fill_row_q);

    for (genvar b = 0; b < ROWS; b++) begin : g_bank
        dwc_row_bank u_bank (
            .clk     (clk),
            .we_i    (xfer && (wr_bank == 3'(b))),
            .re_i    (rd_en),
            .addr_i  (addr),
            .wdata_i (io.s_data),
            .rdata_o (rdata[b])
        );
    end

    always_comb begin
        state_d    = state_q;
        rot_d      = rot_q;
        base_d     = base_q;
        fill_row_d = fill_row_q;
        col_d      = col_q;
        zmask_d    = zmask_q;
        width_d    = width_q;
        height_d   = height_q;
        cfg_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d    = S_FILL;
                        rot_d      = '0;
                        base_d     = '0;
                        fill_row_d = '0;
                        col_d      = '0;
                        zmask_d    = '0;
                        width_d    = cfg_width;
                        height_d   = cfg_height;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (xfer) begin
                    if (row_last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            // rows past the image bottom are never fetched; mask them to zero
                            state_d = S_STREAM;
                            zmask_d = zmask_q | (6'h3F << (3'd1 + fill_row_q));
                        end else begin
                            fill_row_d = fill_row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_STREAM: begin
                if (col_q == ncol - CW'(1)) begin
                    col_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_NEXT: begin
                if (strip_end) begin
                    state_d = S_DONE;
                end else begin
                    // top 2 rows of the new strip are the old rows 4..5, already in the banks
                    state_d    = S_FILL;
                    base_d     = base_q + H_W'(STRIDE_ROWS);
                    rot_d      = rot_add(rot_q, 3'(STRIDE_ROWS));
                    zmask_d    = zmask_q >> STRIDE_ROWS;
                    fill_row_d = 3'(ROWS - STRIDE_ROWS);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rot_q         <= '0;
            base_q        <= '0;
            fill_row_q    <= '0;
            col_q         <= '0;
            zmask_q       <= '0;
            width_q       <= '0;
            height_q      <= '0;
            cfg_err_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            pad_q         <= 1'b0;
            strip_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rot_q         <= rot_d;
            base_q        <= base_d;
            fill_row_q    <= fill_row_d;
            col_q         <= col_d;
            zmask_q       <= zmask_d;
            width_q       <= width_d;
            height_q      <= height_d;
            cfg_err_q     <= cfg_err_d;
            out_valid_q   <= (state_q == S_STREAM);
            pad_q         <= (state_q == S_STREAM) && pad_col;
            strip_start_q <= (state_q == S_STREAM) && (col_q == '0);
        end
    end

    // rot/zmask only change in NEXT, after the last column has left the bank registers
    always_comb begin
        for (int n = 0; n < ROWS; n++) begin
            out_row[n] = '0;
            if (out_valid_q && !pad_q && !zmask_q[n]) out_row[n] = rdata[rot_add(rot_q, 3'(n))];
        end
    end

    assign io.s_ready     = s_ready;
    assign io.out_valid   = out_valid_q;
    assign io.strip_start = strip_start_q;
    assign io.out_row0    = out_row[0];
    assign io.out_row1    = out_row[1];
    assign io.out_row2    = out_row[2];
    assign io.out_row3    = out_row[3];
    assign io.out_row4    = out_row[4];
    assign io.out_row5    = out_row[5];
    assign cfg_err        = cfg_err_q;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = (state_q == S_DONE);
endmodule

// File: tb/tb_dwc_row_feeder.sv
// Directed bench for dwc_row_feeder: frames of several shapes, input gaps,
// rejected configurations and asynchronous reset in the middle of a strip.
module tb_dwc_row_feeder;
    import dwc_pkg::*;

`ifdef DWC_FEEDER_PAD_EN
    localparam int PADC = 1;
`else
    localparam int PADC = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [CW-1:0]  cfg_width = '0;
    logic [H_W-1:0] cfg_height = '0;
    logic           cfg_err, busy, frame_done;

    dwc_row_feeder_if ifc();

    dwc_row_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .frame_done (frame_done),
        .io         (ifc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cap    [0:127][0:5];
    logic       cap_ss [0:127];
    int         run_len[0:15];
    int         n_cols, n_runs, n_hs;
    int         first_valid_cyc, last_fill_cyc, last_valid_cyc, done_cyc;
    bit         done_seen;
    logic       busy_at_done;

    function automatic logic [7:0] pix_at(input int w, input int r, input int c);
        return 8'(r * w + c + 1);
    endfunction

    task automatic run_frame(input int w, input int h, input bit gaps);
        int   pix, total, fill1, cyc;
        logic prev_v;
        total = w * h;
        fill1 = w * ((h < 6) ? h : 6);
        pix = 0; cyc = 0; prev_v = 1'b0;
        n_cols = 0; n_runs = 0; n_hs = 0; done_seen = 1'b0;
        first_valid_cyc = -1; last_fill_cyc = -100; last_valid_cyc = -100; done_cyc = -1;
        busy_at_done = 1'b0;
        @(posedge clk); #1;
        cfg_width = CW'(w); cfg_height = H_W'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || ifc.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ack w=%0d h=%0d: busy=%b s_ready=%b, want 1 1", w, h, busy, ifc.s_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4000 && !done_seen; i++) begin
            if (pix < total && (!gaps || $urandom_range(0, 1) == 1)) begin
                ifc.s_valid = 1'b1;
                ifc.s_data  = pix_at(w, pix / w, pix % w);
            end else begin
                ifc.s_valid = 1'b0;
                ifc.s_data  = '0;
            end
            @(negedge clk);
            cyc++;
            if (ifc.s_valid && ifc.s_ready) begin
                n_hs++;
                pix++;
                if (n_hs == fill1) last_fill_cyc = cyc;
            end
            if (ifc.out_valid) begin
                if (n_cols < 128) begin
                    cap[n_cols][0] = ifc.out_row0; cap[n_cols][1] = ifc.out_row1;
                    cap[n_cols][2] = ifc.out_row2; cap[n_cols][3] = ifc.out_row3;
                    cap[n_cols][4] = ifc.out_row4; cap[n_cols][5] = ifc.out_row5;
                    cap_ss[n_cols] = ifc.strip_start;
                end
                n_cols++;
                if (!prev_v) begin
                    if (n_runs < 16) run_len[n_runs] = 0;
                    n_runs++;
                end
                if (n_runs <= 16) run_len[n_runs-1]++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                last_valid_cyc = cyc;
            end
            prev_v = ifc.out_valid;
            if (frame_done) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                busy_at_done = busy;
            end
            @(posedge clk); #1;
        end
        ifc.s_valid = 1'b0;
    endtask

    task automatic test_frame(input string name, input int w, input int h, input bit gaps);
        int         strips, ncol, ncheck;
        logic [7:0] exp;
        logic       ok;
        strips = (h - 2 + 3) / 4;
        ncol   = w + 2 * PADC;
        run_frame(w, h, gaps);

        n_tests++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL %s frame_done: not seen within cycle budget, want a pulse", name);
        end
        n_tests++;
        if (n_hs != w * h) begin
            n_fail++;
            $display("FAIL %s handshakes: got %0d, want %0d", name, n_hs, w * h);
        end
        n_tests++;
        if (n_runs != strips || n_cols != strips * ncol) begin
            n_fail++;
            $display("FAIL %s strips: got %0d runs %0d cols, want %0d runs %0d cols",
                     name, n_runs, n_cols, strips, strips * ncol);
        end
        for (int r = 0; r < n_runs && r < strips && r < 16; r++) begin
            n_tests++;
            if (run_len[r] != ncol) begin
                n_fail++;
                $display("FAIL %s run%0d length: got %0d, want %0d", name, r, run_len[r], ncol);
            end
        end
        ncheck = (n_cols < strips * ncol) ? n_cols : strips * ncol;
        if (ncheck > 128) ncheck = 128;
        for (int i = 0; i < ncheck; i++) begin
            int s, k;
            s = i / ncol;
            k = i % ncol;
            ok = (cap_ss[i] === (k == 0));
            for (int n = 0; n < 6; n++) begin
                if (PADC == 1 && (k == 0 || k == w + 1)) exp = 8'h00;
                else if (4 * s + n < h)                  exp = pix_at(w, 4 * s + n, k - PADC);
                else                                     exp = 8'h00;
                if (cap[i][n] !== exp) ok = 1'b0;
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s strip%0d col%0d: got %h %h %h %h %h %h ss=%b, want rows from %0d (zero past %0d) ss=%b",
                         name, s, k, cap[i][0], cap[i][1], cap[i][2], cap[i][3], cap[i][4], cap[i][5],
                         cap_ss[i], 4 * s, h, (k == 0));
            end
        end
        n_tests++;
        if (first_valid_cyc - last_fill_cyc != 2) begin
            n_fail++;
            $display("FAIL %s fill_to_valid latency: got %0d, want 2", name, first_valid_cyc - last_fill_cyc);
        end
        n_tests++;
        if (done_cyc != last_valid_cyc + 1 || busy_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done timing: done at %0d busy=%b, want %0d busy=1",
                     name, done_cyc, busy_at_done, last_valid_cyc + 1);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_drop: busy=%b frame_done=%b, want 0 0", name, busy, frame_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, cfg_err, frame_done, ifc.s_ready, ifc.out_valid, ifc.strip_start} !== 6'b0 ||
            {ifc.out_row0, ifc.out_row1, ifc.out_row2, ifc.out_row3, ifc.out_row4, ifc.out_row5} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_in: busy=%b err=%b done=%b rdy=%b ov=%b, want all 0",
                     busy, cfg_err, frame_done, ifc.s_ready, ifc.out_valid);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy, cfg_err, frame_done, ifc.s_ready, ifc.out_valid, ifc.strip_start} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_after: busy=%b err=%b done=%b rdy=%b ov=%b, want all 0",
                     busy, cfg_err, frame_done, ifc.s_ready, ifc.out_valid);
        end
    endtask

    task automatic test_cfg_err(input int w, input int h);
        @(posedge clk); #1;
        cfg_width = CW'(w); cfg_height = H_W'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err w=%0d h=%0d: err=%b busy=%b, want 1 0", w, h, cfg_err, busy);
        end
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || ifc.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_pulse w=%0d h=%0d: err=%b busy=%b rdy=%b, want 0 0 0",
                     w, h, cfg_err, busy, ifc.s_ready);
        end
    endtask

    task automatic test_reset_mid_stream();
        int  pix;
        bit  seen;
        pix = 0; seen = 1'b0;
        @(posedge clk); #1;
        cfg_width = CW'(4); cfg_height = H_W'(6); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            ifc.s_valid = (pix < 24);
            ifc.s_data  = pix_at(4, pix / 4, pix % 4);
            @(negedge clk);
            if (ifc.s_valid && ifc.s_ready) pix++;
            if (ifc.out_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        ifc.s_valid = 1'b0;
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mid_stream_reach: out_valid not seen, want streaming");
        end
        cfg_width = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cfg_err !== 1'b0 || busy !== 1'b1 || ifc.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy: err=%b busy=%b ov=%b, want 0 1 1", cfg_err, busy, ifc.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, cfg_err, frame_done, ifc.s_ready, ifc.out_valid, ifc.strip_start} !== 6'b0 ||
            {ifc.out_row0, ifc.out_row1, ifc.out_row2, ifc.out_row3, ifc.out_row4, ifc.out_row5} !== 48'h0) begin
            n_fail++;
            $display("FAIL mid_stream_reset: busy=%b err=%b done=%b rdy=%b ov=%b row0=%h, want all 0",
                     busy, cfg_err, frame_done, ifc.s_ready, ifc.out_valid, ifc.out_row0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        test_reset();
        test_frame("w4h6", 4, 6, 1'b0);
        test_frame("w4h8", 4, 8, 1'b0);
        test_frame("w3h10", 3, 10, 1'b0);
        test_frame("w3h10_gaps", 3, 10, 1'b1);
        test_frame("w5h7_gaps", 5, 7, 1'b1);
        test_frame("w2h3", 2, 3, 1'b0);
        test_frame("w1h9", 1, 9, 1'b0);
        test_cfg_err(0, 6);
        test_cfg_err(65, 6);
        test_cfg_err(4, 2);
        test_reset_mid_stream();
        test_frame("after_reset_w4h6", 4, 6, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dwc_row_feeder.md
# dwc_row_feeder

Producer side of the depthwise-conv datapath. It accepts a row-major 8-bit feature-map stream over a valid/ready handshake and stores it in a rotating six-row line buffer. It then replays each 6-row strip column by column on `out_row0..5` with `out_valid`, which is the exact input contract of the 4-output-row 3x3 depthwise unit. Consecutive strips advance by 4 input rows and reuse 2 rows. No weights pass through this block.

## Interface
- `DATA_W`, 8, pixel width (signed two's complement)
- `MAX_W`, 64, maximum image width; bank depth
- `H_W`, 10, height/row-counter width
- `clk` in 1 clock
- `rst_n` in 1 reset, asynchronous, active-low
- `start` in 1 frame start pulse; ignored unless idle
- `cfg_width` in $clog2(MAX_W)+1 image width, latched on accepted `start`
- `cfg_height` in H_W image height, latched on accepted `start`
- `cfg_err` out 1 one-cycle pulse: `start` rejected (width 0, width>MAX_W, or height<3)
- `busy` out 1 high from accepted `start` through the `frame_done` cycle
- `s_valid` in 1, `s_data` in DATA_W, `s_ready` out 1: input pixel stream
- `out_valid` out 1 column valid; drives the dwc unit's `in_valid`
- `out_row0..out_row5` out DATA_W each, logical strip rows 0..5 of the current column
- `strip_start` out 1 high with the first column of each strip
- `frame_done` out 1 one-cycle pulse after the last column of the last strip

## Operation
- FSM states: IDLE, FILL, STREAM, NEXT, DONE.
- IDLE → FILL on valid `start`. Clears `rot` = 0, `base_row` = 0, `fill_row` = 0.
- FILL
  - `s_ready` = 1 only while the current logical row index is below `cfg_height`.
  - Pixels are written to bank `(rot+fill_row)%6` at column address 0..W-1.
  - First strip fills logical rows 0..5. Later strips fill rows 2..5.
  - Rows with absolute index ≥ `cfg_height` are not requested. Their `zero_mask` bit is set instead, forcing that row's output to 0. No stream cycles are spent on them.
  - FILL → STREAM when the last required row completes.
- STREAM
  - Issues read address col = 0..W-1 to all six banks. Bank reads are registered, one cycle.
  - `out_rowN` = bank `(rot+N)%6` data, or 0 if `zero_mask[N]`.
  - `out_valid` is contiguous for the whole strip with no gaps. The downstream unit has no backpressure.
  - `s_ready` = 0 throughout.
- NEXT
  - If `base_row+6 ≥ cfg_height`, go to DONE.
  - Otherwise: `base_row += 4`, `rot = (rot+4)%6`, shift `zero_mask` down by 4, go to FILL.
- DONE: pulse `frame_done`, return to IDLE.
- Strip count = ceil((H-2)/4). For example, H=8 gives 2 strips; the second strip has rows 4..7 plus two zero rows.
- Data is passed unmodified; no arithmetic.
- A `start` while busy is ignored and does not raise `cfg_err`.

## Timing
- Reset values:
  - All outputs 0, including `s_ready`, `busy`, `out_valid`, `out_row*`, `strip_start`, `frame_done`, `cfg_err`.
  - FSM in IDLE.
- `start` accepted at cycle t: `busy` = 1 and `s_ready` = 1 at t+1.
- Stream handshake: a pixel transfers on `s_valid & s_ready`. `s_ready` never depends combinationally on `s_valid`.
- Last pixel of a fill accepted at cycle f: STREAM entered at f+1, first `out_valid` at f+2 (read latency 1). `out_valid` stays high for exactly Ncol consecutive cycles.
- NEXT takes one cycle.
- `frame_done` is asserted the cycle after the last `out_valid`. `busy` drops the following cycle.
- `rst_n` asserted mid-frame: immediate return to IDLE. All outputs go to 0. Bank contents are don't-care.

## Configuration
- `DWC_FEEDER_PAD_EN` defined: horizontal same-padding. Each strip emits W+2 columns: one all-zero column, then columns 0..W-1, then one all-zero column. `strip_start` is asserted on the leading zero column.
- `DWC_FEEDER_PAD_EN` undefined: each strip emits exactly W columns, with no zero columns.
- Vertical zero-row behaviour is identical in both builds.

## Structure
- Package `dwc_pkg`:
  - `DATA_W`, `MAX_W`, `ROWS`=6, `STRIDE_ROWS`=4
  - FSM state enum `feeder_state_t`
  - shared pixel typedef `pix_t`
- Sub-module `dwc_row_bank`: MAX_W x DATA_W single-port RAM with registered read. Six instances. A write and a read never occur in the same cycle by construction.

## Test plan
- W=4, H=6, pixels 1..24, no pad → one strip. Column 0 outputs rows {1,5,9,13,17,21}, 4 contiguous `out_valid`, then `frame_done`. 24 handshakes total.
- W=4, H=8, pixels 1..32 → strip 2 column 0 = {17,21,25,29,0,0}. Strip 2 fills only 8 pixels. `rot` = 4 during strip 2.
- W=3, H=10 → 2 strips, rows 0..5 then 4..9. Strip 2 reuses rows 4 and 5 without re-reading them; 30 handshakes total.
- Random `s_valid` gaps at 50% → output columns and counts identical to the gap-free run. `out_valid` has no internal gaps.
- `DWC_FEEDER_PAD_EN`, W=4, H=6 → 6 columns per strip; the first and last columns are all zeros.
- `start` with `cfg_width`=0 → `cfg_err` pulse, `busy` stays 0. `rst_n` low mid-STREAM → all outputs 0 next cycle, then a new `start` runs a clean frame.
